// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: controller states, BPF ALU opcodes
// and the captured-operand record.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_MUL = 4'h2;
    localparam logic [3:0] ALU_DIV = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_AND = 4'h5;
    localparam logic [3:0] ALU_LSH = 4'h6;
    localparam logic [3:0] ALU_RSH = 4'h7;
    localparam logic [3:0] ALU_NEG = 4'h8;
    localparam logic [3:0] ALU_MOD = 4'h9;
    localparam logic [3:0] ALU_XOR = 4'hA;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// searching with wrap-around, returned both one-hot and encoded.
module alu_arbiter_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             any
);

    int j;

    always_comb begin
        idx = '0;
        j   = 0;
        // Walk the ring backwards so the candidate closest to ptr is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) idx = PW'(j);
        end
        any = |req;
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered BPF ALU among N_REQ
// requesters; one operation in flight, IDLE -> ISSUE -> WAIT -> IDLE.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter bit PESS  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_en,
    input  logic [N_REQ*32-1:0] req_A,
    input  logic [N_REQ*32-1:0] req_B,
    input  logic [N_REQ*4-1:0]  req_sel,
    output logic [N_REQ-1:0]    req_gnt,
    output logic [N_REQ-1:0]    rsp_vld,
    input  logic [N_REQ-1:0]    rsp_ack,
    output logic [31:0]         rsp_out,
    output logic                rsp_eq,
    output logic                rsp_gt,
    output logic                rsp_ge,
    output logic                rsp_set,
    output logic [31:0]         alu_A,
    output logic [31:0]         alu_B,
    output logic [3:0]          alu_sel,
    output logic                alu_en,
    input  logic [31:0]         alu_out,
    input  logic                alu_eq,
    input  logic                alu_gt,
    input  logic                alu_ge,
    input  logic                alu_set,
    input  logic                alu_vld,
    output logic                alu_ack
);

    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0][31:0] a_arr;
    logic [N_REQ-1:0][31:0] b_arr;
    logic [N_REQ-1:0][3:0]  sel_arr;

    arb_state_t       state, state_nxt;
    logic [PW-1:0]    rr_ptr, owner, pick_idx;
    logic [N_REQ-1:0] pick_gnt, owner_oh;
    logic             pick_any, take, wait_vld;
    alu_op_t          op_q;

    assign a_arr   = req_A;
    assign b_arr   = req_B;
    assign sel_arr = req_sel;

    alu_arbiter_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .req (req_en),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Gating with rst_n keeps the combinational grant quiet while reset is held.
    assign take     = rst_n && (state == ST_IDLE) && pick_any;
    assign wait_vld = (state == ST_WAIT) && alu_vld;
    assign owner_oh = N_REQ'(1) << owner;

    assign alu_A   = op_q.a;
    assign alu_B   = op_q.b;
    assign alu_sel = op_q.sel;
    assign alu_en  = (state == ST_ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (take) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (alu_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            op_q   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner    <= pick_idx;
                rr_ptr   <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
                op_q.a   <= a_arr[pick_idx];
                op_q.b   <= b_arr[pick_idx];
                op_q.sel <= sel_arr[pick_idx];
            end
        end
    end

    generate
        if (PESS) begin : g_pess
            logic [N_REQ-1:0] gnt_q, vld_q;
            logic [31:0]      out_q;
            logic [3:0]       flg_q;

            // vld_q holds only the owner bit, so a non-owner ack can never match.
            assign alu_ack = wait_vld && |(vld_q & rsp_ack);
            assign req_gnt = gnt_q;
            assign rsp_vld = vld_q;
            assign rsp_out = out_q;
            assign {rsp_eq, rsp_gt, rsp_ge, rsp_set} = flg_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    gnt_q <= '0;
                    vld_q <= '0;
                    out_q <= '0;
                    flg_q <= '0;
                end else begin
                    gnt_q <= take ? pick_gnt : '0;
                    vld_q <= (wait_vld && !alu_ack) ? owner_oh : '0;
                    if (wait_vld) begin
                        out_q <= alu_out;
                        flg_q <= {alu_eq, alu_gt, alu_ge, alu_set};
                    end
                end
            end
        end else begin : g_comb
            assign alu_ack = wait_vld && rsp_ack[owner];
            assign req_gnt = take ? pick_gnt : '0;
            assign rsp_vld = wait_vld ? owner_oh : '0;
            assign rsp_out = alu_out;
            assign {rsp_eq, rsp_gt, rsp_ge, rsp_set} = {alu_eq, alu_gt, alu_ge, alu_set};
        end
    endgenerate

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (N_REQ=2, PESS=0) with a registered BPF ALU model and
// a transaction-level round-robin reference.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_en, req_gnt, rsp_vld, rsp_ack;
    logic [N*32-1:0]   req_A, req_B;
    logic [N*4-1:0]    req_sel;
    logic [31:0]       rsp_out, alu_A, alu_B, alu_out;
    logic              rsp_eq, rsp_gt, rsp_ge, rsp_set;
    logic [3:0]        alu_sel;
    logic              alu_en, alu_eq, alu_gt, alu_ge, alu_set, alu_vld, alu_ack;

    int tests_run    = 0;
    int tests_failed = 0;
    int ptr_m        = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .PESS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en), .req_A(req_A), .req_B(req_B), .req_sel(req_sel),
        .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_ack(rsp_ack),
        .rsp_out(rsp_out), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_ge(rsp_ge), .rsp_set(rsp_set),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_en(alu_en),
        .alu_out(alu_out), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_ge(alu_ge), .alu_set(alu_set),
        .alu_vld(alu_vld), .alu_ack(alu_ack)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        case (s)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_MUL: return a * b;
            ALU_DIV: return (b == 0) ? 32'd0 : a / b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            ALU_LSH: return a << b[4:0];
            ALU_RSH: return a >> b[4:0];
            ALU_NEG: return -a;
            ALU_MOD: return (b == 0) ? 32'd0 : a % b;
            ALU_XOR: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU: result one cycle after enable, valid held until acked.
    always @(posedge clk) begin
        if (!rst_n) begin
            {alu_out, alu_eq, alu_gt, alu_ge, alu_set, alu_vld} <= '0;
        end else if (alu_en) begin
            alu_out <= alu_ref(alu_A, alu_B, alu_sel);
            alu_eq  <= (alu_A == alu_B);
            alu_gt  <= (alu_A > alu_B);
            alu_ge  <= (alu_A >= alu_B);
            alu_set <= ((alu_A & alu_B) != 0);
            alu_vld <= 1'b1;
        end else if (alu_ack) begin
            alu_vld <= 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s);
        req_A[i*32 +: 32] = a;
        req_B[i*32 +: 32] = b;
        req_sel[i*4 +: 4] = s;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_en = '0; rsp_ack = '0; req_A = '0; req_B = '0; req_sel = '0;
        step; step;
        @(negedge clk);
        tests_run++;
        if ({req_gnt, rsp_vld, alu_en, alu_ack, alu_A, alu_B, alu_sel, rsp_out,
             rsp_eq, rsp_gt, rsp_ge, rsp_set} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: gnt=%b vld=%b en=%b ack=%b A=%h B=%h sel=%h out=%h, all must be 0",
                     req_gnt, rsp_vld, alu_en, alu_ack, alu_A, alu_B, alu_sel, rsp_out);
        end
        step;
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_single;
        req_en = 2'b01; set_req(0, 32'd5, 32'd3, ALU_ADD);
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b01) begin tests_failed++; $display("FAIL single_gnt: got %b exp 01", req_gnt); end
        step;
        req_en = 2'b00; rsp_ack = 2'b01;
        @(negedge clk);
        tests_run++;
        if ({alu_en, alu_A, alu_B, alu_sel, rsp_vld} !== {1'b1, 32'd5, 32'd3, ALU_ADD, 2'b00}) begin
            tests_failed++;
            $display("FAIL single_issue: en=%b A=%h B=%h sel=%h vld=%b exp en=1 A=5 B=3 sel=0 vld=00",
                     alu_en, alu_A, alu_B, alu_sel, rsp_vld);
        end
        step;
        @(negedge clk);
        tests_run++;
        if ({rsp_vld, rsp_out, rsp_eq, rsp_gt, rsp_ge, alu_ack, alu_en} !==
            {2'b01, 32'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_rsp: vld=%b out=%0d eq=%b gt=%b ge=%b ack=%b en=%b exp vld=01 out=8 eq=0 gt=1 ge=1 ack=1 en=0",
                     rsp_vld, rsp_out, rsp_eq, rsp_gt, rsp_ge, alu_ack, alu_en);
        end
        step;
        rsp_ack = 2'b00;
        ptr_m = 1;
    endtask

    task automatic test_contention;
        int g;
        req_en = 2'b11; rsp_ack = 2'b11;
        set_req(0, 32'd2, 32'd9, ALU_ADD);
        set_req(1, 32'd7, 32'd7, ALU_SUB);
        for (int op = 0; op < 4; op++) begin
            g = ptr_m;
            @(negedge clk);
            tests_run++;
            if (req_gnt !== N'(1) << g) begin
                tests_failed++; $display("FAIL contention_gnt%0d: got %b exp idx %0d", op, req_gnt, g);
            end
            ptr_m = (g + 1) % N;
            step;
            @(negedge clk);
            tests_run++;
            if ({alu_en, alu_A} !== {1'b1, (g == 1) ? 32'd7 : 32'd2}) begin
                tests_failed++; $display("FAIL contention_issue%0d: en=%b A=%h", op, alu_en, alu_A);
            end
            step;
            @(negedge clk);
            tests_run++;
            if ({rsp_vld, alu_ack, rsp_out, rsp_eq} !==
                {N'(1) << g, 1'b1, (g == 1) ? 32'd0 : 32'd11, (g == 1)}) begin
                tests_failed++;
                $display("FAIL contention_rsp%0d: vld=%b ack=%b out=%0d eq=%b for owner %0d",
                         op, rsp_vld, alu_ack, rsp_out, rsp_eq, g);
            end
            step;
        end
        req_en = 2'b00; rsp_ack = 2'b00;
    endtask

    task automatic test_delayed_ack;
        req_en = 2'b01;
        set_req(0, 32'h1234, 32'h10, ALU_XOR);
        set_req(1, 32'd100, 32'd4, ALU_DIV);
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b01) begin tests_failed++; $display("FAIL delayed_gnt0: got %b exp 01", req_gnt); end
        step;
        req_en = 2'b10;
        step;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            tests_run++;
            if ({rsp_vld, rsp_out, alu_en, alu_ack, req_gnt} !==
                {2'b01, 32'h1224, 1'b0, 1'b0, 2'b00}) begin
                tests_failed++;
                $display("FAIL delayed_hold%0d: vld=%b out=%h en=%b ack=%b gnt=%b exp vld=01 out=1224 en=0 ack=0 gnt=00",
                         h, rsp_vld, rsp_out, alu_en, alu_ack, req_gnt);
            end
            step;
        end
        rsp_ack = 2'b01;
        @(negedge clk);
        tests_run++;
        if (alu_ack !== 1'b1) begin tests_failed++; $display("FAIL delayed_ack: got %b exp 1", alu_ack); end
        step;
        rsp_ack = 2'b00;
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b10) begin tests_failed++; $display("FAIL delayed_next_gnt: got %b exp 10", req_gnt); end
        step;
        req_en = 2'b00;
        step;
        rsp_ack = 2'b10;
        @(negedge clk);
        tests_run++;
        if ({rsp_vld, rsp_out, alu_ack} !== {2'b10, 32'd25, 1'b1}) begin
            tests_failed++; $display("FAIL delayed_second_rsp: vld=%b out=%0d ack=%b exp 10 25 1", rsp_vld, rsp_out, alu_ack);
        end
        step;
        rsp_ack = 2'b00;
        ptr_m = 0;
    endtask

    task automatic test_stray_ack;
        req_en = 2'b10;
        set_req(1, 32'd3, 32'd6, ALU_MUL);
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b10) begin tests_failed++; $display("FAIL stray_gnt: got %b exp 10", req_gnt); end
        step;
        req_en = 2'b00; rsp_ack = 2'b01;
        step;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            tests_run++;
            if ({alu_ack, rsp_vld} !== {1'b0, 2'b10}) begin
                tests_failed++; $display("FAIL stray_ignored%0d: ack=%b vld=%b exp ack=0 vld=10", h, alu_ack, rsp_vld);
            end
            step;
        end
        rsp_ack = 2'b10;
        @(negedge clk);
        tests_run++;
        if ({alu_ack, rsp_out} !== {1'b1, 32'd18}) begin
            tests_failed++; $display("FAIL stray_owner_ack: ack=%b out=%0d exp 1 18", alu_ack, rsp_out);
        end
        step;
        rsp_ack = 2'b00;
        ptr_m = 0;
    endtask

    task automatic test_reset_mid;
        req_en = 2'b01;
        set_req(0, 32'd40, 32'd2, ALU_SUB);
        set_req(1, 32'hF0, 32'h0F, ALU_OR);
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b01) begin tests_failed++; $display("FAIL rstmid_gnt: got %b exp 01", req_gnt); end
        step;
        req_en = 2'b00; rst_n = 1'b0;
        step;
        @(negedge clk);
        tests_run++;
        if ({req_gnt, rsp_vld, alu_en, alu_ack, alu_A, alu_B, alu_sel, rsp_out} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: gnt=%b vld=%b en=%b ack=%b A=%h B=%h sel=%h out=%h, all must be 0",
                     req_gnt, rsp_vld, alu_en, alu_ack, alu_A, alu_B, alu_sel, rsp_out);
        end
        step;
        rst_n = 1'b1; req_en = 2'b11; rsp_ack = 2'b11;
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b01) begin tests_failed++; $display("FAIL rstmid_ptr_cleared: got %b exp 01", req_gnt); end
        step;
        req_en = 2'b10;
        step;
        step;
        @(negedge clk);
        tests_run++;
        if (req_gnt !== 2'b10) begin tests_failed++; $display("FAIL rstmid_req1_gnt: got %b exp 10", req_gnt); end
        step;
        req_en = 2'b00;
        step;
        @(negedge clk);
        tests_run++;
        if ({rsp_vld, rsp_out, alu_ack} !== {2'b10, 32'hFF, 1'b1}) begin
            tests_failed++; $display("FAIL rstmid_req1_rsp: vld=%b out=%h ack=%b exp 10 ff 1", rsp_vld, rsp_out, alu_ack);
        end
        step;
        rsp_ack = 2'b00;
        ptr_m = 0;
    endtask

    task automatic test_operand_capture;
        req_en = 2'b01;
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        step;
        req_en = 2'b00;
        req_A[31:0] = 32'hFFFF_FFFF;
        @(negedge clk);
        tests_run++;
        if (alu_A !== 32'd1) begin tests_failed++; $display("FAIL capture_alu_A: got %h exp 00000001", alu_A); end
        step;
        rsp_ack = 2'b01;
        @(negedge clk);
        tests_run++;
        if ({rsp_vld, rsp_out} !== {2'b01, 32'd3}) begin
            tests_failed++; $display("FAIL capture_rsp: vld=%b out=%h exp 01 00000003", rsp_vld, rsp_out);
        end
        step;
        rsp_ack = 2'b00;
        ptr_m = 1;
    endtask

    // Transaction model: a grant goes to the first pending index from ptr; the
    // operation issues one cycle later and is valid from the second cycle on.
    task automatic test_random;
        logic [N-1:0] pend, exp_gnt, exp_vld;
        logic [31:0]  oa[N], ob[N], ca, cb;
        logic [3:0]   os[N], cs;
        int           owner, age, ptr, idx, j;
        bit           busy, exp_ack;
        rst_n = 1'b0; req_en = '0; rsp_ack = '0;
        step; step;
        rst_n = 1'b1;
        pend = '0; busy = 0; ptr = 0; age = 0; owner = 0; ca = '0; cb = '0; cs = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    oa[i]   = $urandom;
                    ob[i]   = ($urandom_range(0, 3) == 0) ? oa[i] : 32'($urandom_range(0, 40));
                    os[i]   = 4'($urandom_range(0, 10));
                    pend[i] = ($urandom_range(0, 1) == 1);
                    set_req(i, oa[i], ob[i], os[i]);
                end
            end
            req_en  = pend;
            rsp_ack = N'($urandom_range(0, (1 << N) - 1));
            @(negedge clk);
            if (!busy) begin
                idx = -1;
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (idx < 0 && pend[j]) idx = j;
                end
                exp_gnt = (idx < 0) ? '0 : N'(1) << idx;
                tests_run++;
                if ({req_gnt, alu_en, alu_ack, rsp_vld} !== {exp_gnt, 1'b0, 1'b0, {N{1'b0}}}) begin
                    tests_failed++;
                    $display("FAIL rand_idle c%0d: gnt=%b en=%b ack=%b vld=%b exp gnt=%b en=0 ack=0 vld=0",
                             c, req_gnt, alu_en, alu_ack, rsp_vld, exp_gnt);
                end
                if (idx >= 0) begin
                    owner = idx; ca = oa[idx]; cb = ob[idx]; cs = os[idx];
                    busy = 1; age = 0; ptr = (idx + 1) % N; pend[idx] = 1'b0;
                end
            end else begin
                age++;
                exp_vld = (age >= 2) ? N'(1) << owner : '0;
                exp_ack = (age >= 2) && rsp_ack[owner];
                tests_run++;
                if ({req_gnt, alu_en, rsp_vld, alu_ack} !== {{N{1'b0}}, (age == 1), exp_vld, exp_ack}) begin
                    tests_failed++;
                    $display("FAIL rand_busy c%0d: gnt=%b en=%b vld=%b ack=%b exp gnt=0 en=%b vld=%b ack=%b",
                             c, req_gnt, alu_en, rsp_vld, alu_ack, (age == 1), exp_vld, exp_ack);
                end
                tests_run++;
                if (age == 1) begin
                    if ({alu_A, alu_B, alu_sel} !== {ca, cb, cs}) begin
                        tests_failed++;
                        $display("FAIL rand_operands c%0d: A=%h B=%h sel=%h exp %h %h %h", c, alu_A, alu_B, alu_sel, ca, cb, cs);
                    end
                end else if ({rsp_out, rsp_eq, rsp_gt, rsp_ge, rsp_set} !==
                             {alu_ref(ca, cb, cs), ca == cb, ca > cb, ca >= cb, (ca & cb) != 0}) begin
                    tests_failed++;
                    $display("FAIL rand_result c%0d: out=%h flags=%b%b%b%b exp out=%h for A=%h B=%h sel=%h",
                             c, rsp_out, rsp_eq, rsp_gt, rsp_ge, rsp_set, alu_ref(ca, cb, cs), ca, cb, cs);
                end
                if (exp_ack) busy = 0;
            end
            step;
        end
        req_en = '0; rsp_ack = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_delayed_ack;
        test_stray_ack;
        test_reset_mid;
        test_operand_capture;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
